// File: rtl/execute_stage.sv
`timescale 1ns/1ps
// Execute stage: ALU, conditional-branch resolution and the EX/MEM pipeline
// register with stall/flush control, plus a sticky illegal-code flag and a
// taken-branch counter for debug.
module execute_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [2:0]       aluop_i,
    input  logic [3:0]       alu_control_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             reg_write_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [XLEN-1:0]  store_data_o,
    output logic [4:0]       rd_addr_o,
    output logic             branch_taken_o,
    output logic [XLEN-1:0]  branch_target_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] branch_cnt_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_SGE  = 4'b1011,
        ALU_SGEU = 4'b1100,
        ALU_ILL  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_R = 3'b001,
        CLS_I = 3'b010,
        CLS_S = 3'b011,
        CLS_L = 3'b100,
        CLS_B = 3'b110
    } alu_class_e;

    alu_op_e          w_op;
    logic [4:0]       w_shamt;
    logic [XLEN-1:0]  w_result;
    logic             w_cond;
    logic             w_is_branch;
    logic             w_taken;
    logic             w_illegal;
    logic             w_ctrl_en;

    logic             r_valid;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [XLEN-1:0]  r_alu_result;
    logic [XLEN-1:0]  r_store_data;
    logic [4:0]       r_rd_addr;
    logic             r_branch_taken;
    logic [XLEN-1:0]  r_branch_target;
    logic             r_illegal;
    logic [CNT_W-1:0] r_branch_cnt;

    assign w_op    = alu_op_e'(alu_control_i);
    assign w_shamt = op_b_i[4:0];

    // ALU result; compares produce a zero-extended 0/1
    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_ADD:  w_result = rs1_data_i + op_b_i;
            ALU_SUB:  w_result = rs1_data_i - op_b_i;
            ALU_SLL:  w_result = rs1_data_i << w_shamt;
            ALU_SLT:  w_result[0] = $signed(rs1_data_i) < $signed(op_b_i);
            ALU_SLTU: w_result[0] = rs1_data_i < op_b_i;
            ALU_XOR:  w_result = rs1_data_i ^ op_b_i;
            ALU_SRL:  w_result = rs1_data_i >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(rs1_data_i) >>> w_shamt);
            ALU_OR:   w_result = rs1_data_i | op_b_i;
            ALU_AND:  w_result = rs1_data_i & op_b_i;
            ALU_SGE:  w_result[0] = $signed(rs1_data_i) >= $signed(op_b_i);
            ALU_SGEU: w_result[0] = rs1_data_i >= op_b_i;
            default:  w_result = '0;
        endcase
    end

    // Branch condition derived from the ALU result for the branch codes
    always_comb begin
        w_cond = 1'b0;
        case (w_op)
            ALU_XOR:  w_cond = (w_result == '0);
            ALU_SUB:  w_cond = (w_result != '0);
            ALU_SLT, ALU_SLTU, ALU_SGE, ALU_SGEU:
                      w_cond = (w_result == XLEN'(1));
            default:  w_cond = 1'b0;
        endcase
    end

    assign w_is_branch = valid_i && (alu_class_e'(aluop_i) == CLS_B);
    assign w_taken     = w_is_branch && w_cond;
    assign w_illegal   = valid_i && (w_op == ALU_ILL);
    assign w_ctrl_en   = valid_i && !w_is_branch && !w_illegal;

    // EX/MEM register: flush beats stall; stall holds everything but the pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid         <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_rd_addr       <= '0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_illegal       <= 1'b0;
            r_branch_cnt    <= '0;
        end else if (flush_i) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_branch_taken <= 1'b0;
        end else if (stall_i) begin
            r_branch_taken <= 1'b0;
        end else begin
            r_valid         <= valid_i;
            r_reg_write     <= w_ctrl_en && reg_write_i;
            r_mem_read      <= w_ctrl_en && mem_read_i;
            r_mem_write     <= w_ctrl_en && mem_write_i;
            r_alu_result    <= w_result;
            r_store_data    <= rs2_data_i;
            r_rd_addr       <= rd_addr_i;
            r_branch_taken  <= w_taken;
            r_branch_target <= pc_i + imm_i;
            r_branch_cnt    <= r_branch_cnt + {{(CNT_W-1){1'b0}}, w_taken};
            if (w_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign valid_o         = r_valid;
    assign reg_write_o     = r_reg_write;
    assign mem_read_o      = r_mem_read;
    assign mem_write_o     = r_mem_write;
    assign alu_result_o    = r_alu_result;
    assign store_data_o    = r_store_data;
    assign rd_addr_o       = r_rd_addr;
    assign branch_taken_o  = r_branch_taken;
    assign branch_target_o = r_branch_target;
    assign illegal_o       = r_illegal;
    assign branch_cnt_o    = r_branch_cnt;

endmodule

// File: tb/tb_execute_stage.sv
`timescale 1ns/1ps
// Bench for execute_stage: directed steps from the test plan, then random
// traffic, all compared against a behavioural model of the EX/MEM register.
module tb_execute_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic [2:0]       aluop_i;
    logic [3:0]       alu_control_i;
    logic [XLEN-1:0]  rs1_data_i, op_b_i, rs2_data_i, pc_i, imm_i;
    logic [4:0]       rd_addr_i;
    logic             reg_write_i, mem_read_i, mem_write_i, stall_i, flush_i;
    logic             valid_o, reg_write_o, mem_read_o, mem_write_o;
    logic [XLEN-1:0]  alu_result_o, store_data_o, branch_target_o;
    logic [4:0]       rd_addr_o;
    logic             branch_taken_o, illegal_o;
    logic [CNT_W-1:0] branch_cnt_o;

    execute_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .aluop_i(aluop_i),
        .alu_control_i(alu_control_i), .rs1_data_i(rs1_data_i), .op_b_i(op_b_i),
        .rs2_data_i(rs2_data_i), .pc_i(pc_i), .imm_i(imm_i), .rd_addr_i(rd_addr_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .alu_result_o(alu_result_o), .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .illegal_o(illegal_o), .branch_cnt_o(branch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Expected architectural view of the EX/MEM register
    bit        e_valid, e_rw, e_mr, e_mw, e_taken, e_ill;
    bit [31:0] e_res, e_sd, e_tgt;
    bit [4:0]  e_rd;
    int        e_cnt;
    int        saved_cnt;

    function automatic bit [31:0] ref_alu(int code, bit [31:0] a, bit [31:0] b);
        int sh = int'(b % 32);
        int sa = $signed(a);
        int sb = $signed(b);
        case (code)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'(sa >>> sh);
            8:  return a | b;
            9:  return a & b;
            11: return (sa >= sb) ? 32'd1 : 32'd0;
            12: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // beq compares via xor, bne via sub, ordered branches via compare codes
    function automatic bit ref_branch(int code, bit [31:0] a, bit [31:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        case (code)
            5:  return a == b;
            1:  return a != b;
            3:  return sa < sb;
            4:  return a < b;
            11: return sa >= sb;
            12: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_taken = 0; e_ill = 0;
        e_res = '0; e_sd = '0; e_tgt = '0; e_rd = '0; e_cnt = 0;
    endtask

    task automatic model_step();
        int  code = int'(alu_control_i);
        bit  is_b = valid_i && (aluop_i == 3'b110);
        bit  ill  = valid_i && (code == 15);
        bit  wr_ok = valid_i && !is_b && !ill;
        if (flush_i) begin
            e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_taken = 0;
        end else if (stall_i) begin
            e_taken = 0;
        end else begin
            e_valid = valid_i;
            e_rw    = wr_ok && reg_write_i;
            e_mr    = wr_ok && mem_read_i;
            e_mw    = wr_ok && mem_write_i;
            e_res   = ref_alu(code, rs1_data_i, op_b_i);
            e_sd    = rs2_data_i;
            e_rd    = rd_addr_i;
            e_tgt   = pc_i + imm_i;
            e_taken = is_b && ref_branch(code, rs1_data_i, op_b_i);
            if (e_taken) e_cnt = (e_cnt + 1) % (1 << CNT_W);
            if (ill) e_ill = 1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        chk({tag, ".rw"},    32'(reg_write_o), 32'(e_rw));
        chk({tag, ".mr"},    32'(mem_read_o), 32'(e_mr));
        chk({tag, ".mw"},    32'(mem_write_o), 32'(e_mw));
        chk({tag, ".taken"}, 32'(branch_taken_o), 32'(e_taken));
        chk({tag, ".ill"},   32'(illegal_o), 32'(e_ill));
        chk({tag, ".cnt"},   32'(branch_cnt_o), 32'(e_cnt));
        if (e_valid) begin
            chk({tag, ".res"}, alu_result_o, e_res);
            chk({tag, ".sd"},  store_data_o, e_sd);
            chk({tag, ".rd"},  32'(rd_addr_o), 32'(e_rd));
            chk({tag, ".tgt"}, branch_target_o, e_tgt);
        end
    endtask

    task automatic issue(bit v, bit [2:0] aop, bit [3:0] code, bit [31:0] a,
                         bit [31:0] b, bit rw, bit st, bit fl);
        valid_i = v; aluop_i = aop; alu_control_i = code;
        rs1_data_i = a; op_b_i = b; reg_write_i = rw;
        mem_read_i = (aop == 3'b100); mem_write_i = (aop == 3'b011);
        rs2_data_i = $urandom; pc_i = $urandom; imm_i = $urandom;
        rd_addr_i = 5'($urandom);
        stall_i = st; flush_i = fl;
    endtask

    task automatic tick(string tag);
        @(posedge clk_i);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic reset_pulse(string tag);
        #1 rst_ni = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".res0"}, alu_result_o, 32'd0);
        chk({tag, ".tgt0"}, branch_target_o, 32'd0);
        chk({tag, ".sd0"},  store_data_o, 32'd0);
        #1 rst_ni = 1'b1;
    endtask

    task automatic rand_issue();
        bit [2:0] cls[5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        bit [3:0] code = 4'($urandom);
        bit [31:0] a = $urandom;
        bit [31:0] b;
        if (code == 4'hF && ($urandom % 8) != 0) code = 4'h0;
        case ($urandom % 4)
            0: b = a;
            1: b = $urandom % 64;
            default: b = $urandom;
        endcase
        issue(($urandom % 4) != 0, cls[$urandom % 5], code, a, b,
              1'($urandom), ($urandom % 6) == 0, ($urandom % 8) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        model_reset();
        issue(1, 3'b001, 4'h0, 32'h1, 32'h2, 1, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_all("rst_init");

        // Random inputs captured, then an asynchronous reset between edges
        rand_issue(); stall_i = 0; flush_i = 0;
        tick("pre_rst");
        reset_pulse("rst_async");

        // ALU ops with A=0xFFFFFFF0, B=4
        issue(1, 3'b001, 4'h0, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("add");
        chk("add.k", alu_result_o, 32'hFFFFFFF4);
        issue(1, 3'b001, 4'h1, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sub");
        chk("sub.k", alu_result_o, 32'hFFFFFFEC);
        issue(1, 3'b001, 4'h2, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sll");
        chk("sll.k", alu_result_o, 32'hFFFFFF00);
        issue(1, 3'b001, 4'h6, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("srl");
        chk("srl.k", alu_result_o, 32'h0FFFFFFF);
        issue(1, 3'b001, 4'h7, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sra");
        chk("sra.k", alu_result_o, 32'hFFFFFFFF);
        issue(1, 3'b001, 4'h3, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("slt");
        chk("slt.k", alu_result_o, 32'h1);
        issue(1, 3'b001, 4'h4, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sltu");
        chk("sltu.k", alu_result_o, 32'h0);
        issue(1, 3'b001, 4'hB, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sge");
        chk("sge.k", alu_result_o, 32'h0);
        issue(1, 3'b001, 4'hC, 32'hFFFFFFF0, 32'h4, 1, 0, 0); tick("sgeu");
        chk("sgeu.k", alu_result_o, 32'h1);
        issue(1, 3'b010, 4'h2, 32'hFFFFFFF0, 32'h25, 1, 0, 0); tick("sll5");
        chk("sll5.k", alu_result_o, 32'hFFFFFE00);
        chk("sll5.rw", 32'(reg_write_o), 32'd1);

        // Branches: pc=0x100, imm=0x20
        issue(1, 3'b110, 4'h5, 32'h5, 32'h5, 1, 0, 0);
        pc_i = 32'h100; imm_i = 32'h20; tick("beq");
        chk("beq.taken", 32'(branch_taken_o), 32'd1);
        chk("beq.tgt", branch_target_o, 32'h120);
        chk("beq.rw", 32'(reg_write_o), 32'd0);
        chk("beq.cnt", 32'(branch_cnt_o), 32'd1);
        issue(1, 3'b110, 4'h1, 32'h7, 32'h7, 1, 0, 0);
        pc_i = 32'h100; imm_i = 32'h20; tick("bne");
        chk("bne.taken", 32'(branch_taken_o), 32'd0);
        issue(1, 3'b110, 4'hC, 32'h1, 32'hFFFFFFFF, 1, 0, 0); tick("bgeu");
        chk("bgeu.taken", 32'(branch_taken_o), 32'd0);

        // Taken beq then a 3-cycle stall: pulse lasts one cycle, count holds
        issue(1, 3'b110, 4'h5, 32'h9, 32'h9, 0, 0, 0); tick("stl.beq");
        chk("stl.beq.taken", 32'(branch_taken_o), 32'd1);
        saved_cnt = e_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(1, 3'b110, 4'h5, 32'h3, 32'h3, 1, 1, 0); tick("stall");
            chk("stall.taken", 32'(branch_taken_o), 32'd0);
            chk("stall.cnt", 32'(branch_cnt_o), 32'(saved_cnt));
        end
        issue(1, 3'b001, 4'h0, 32'h1, 32'h1, 1, 1, 1); tick("stl_fl");
        chk("stl_fl.valid", 32'(valid_o), 32'd0);

        // Illegal code: bubble leaves flag clear, real one sets it for good
        issue(0, 3'b001, 4'hF, 32'h1, 32'h1, 1, 0, 0); tick("ill_bub");
        chk("ill_bub.ill", 32'(illegal_o), 32'd0);
        issue(1, 3'b001, 4'hF, 32'h1, 32'h1, 1, 0, 0); tick("ill");
        chk("ill.valid", 32'(valid_o), 32'd1);
        chk("ill.rw", 32'(reg_write_o), 32'd0);
        chk("ill.ill", 32'(illegal_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            issue(1, 3'b010, 4'($urandom % 10), $urandom, $urandom, 1, 0, 0);
            tick("legal");
        end
        chk("ill.sticky", 32'(illegal_o), 32'd1);

        // Counter wrap: 17 taken branches from zero
        reset_pulse("rst_wrap");
        for (int i = 0; i < 17; i++) begin
            issue(1, 3'b110, 4'h5, 32'h42, 32'h42, 0, 0, 0); tick("wrap");
        end
        chk("wrap.cnt", 32'(branch_cnt_o), 32'd1);

        // Reset during a stall discards the held instruction
        issue(1, 3'b001, 4'h0, 32'h10, 32'h20, 1, 0, 0); tick("mid.load");
        issue(1, 3'b001, 4'h0, 32'h10, 32'h20, 1, 1, 0); tick("mid.stall");
        reset_pulse("mid.rst");
        tick("mid.after");
        chk("mid.valid", 32'(valid_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_issue();
            tick("rand");
            if (i == 200) reset_pulse("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
